// File: rtl/mii_tx_arbiter.sv
// Round-robin MII transmit arbiter: wraps granted source frames in
// START/EOF, pads short frames, truncates long ones, inserts fixed IPG.
module mii_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int MIN_WORDS = 5,
  parameter int MAX_WORDS = 17,
  parameter int IPG_WORDS = 2,
  parameter logic [7:0] IDLE_CODE = 8'h07,
  parameter logic [7:0] START_CODE = 8'hFB,
  parameter logic [7:0] EOF_CODE = 8'hFD,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
  input  logic [NUM_SRC-1:0] i_src_valid,
  input  logic [NUM_SRC-1:0] i_src_last,
  output logic [NUM_SRC-1:0] o_src_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic [NUM_SRC-1:0] o_grant,
  output logic o_frame_done,
  output logic o_trunc,
  output logic o_underrun
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam int IW = $clog2(IPG_WORDS + 1);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [DATA_WIDTH-1:0] W_IDLE = {NB{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] W_START =
    {{(NB-1){IDLE_CODE}}, START_CODE};
  localparam logic [DATA_WIDTH-1:0] W_EOF =
    {EOF_CODE, {(NB-1){IDLE_CODE}}};
  localparam logic [DATA_WIDTH-1:0] W_PAD = {NB{PAD_BYTE}};
  localparam logic [CTRL_WIDTH-1:0] C_CTL = '1;
  localparam logic [WW-1:0] MIN_W = WW'(MIN_WORDS);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WORDS);
  localparam logic [IW-1:0] IPG_W = IW'(IPG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PAD, S_EOF, S_IPG, S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ipg_q, ipg_d;
  logic trunc_q, trunc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic done_q, done_d;
  logic trp_q, trp_d;
  logic und_q, und_d;

  logic req_any;
  logic [PW-1:0] win;
  logic sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [WW-1:0] cnt_inc;
  logic [IW-1:0] ipg_inc;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] a, input int b);
    int t;
    t = int'(a) + b;
    if (t >= NUM_SRC) t = t - NUM_SRC;
    return t[PW-1:0];
  endfunction

  // highest offset first so the nearest requester wins last
  always_comb begin
    req_any = 1'b0;
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (i_src_valid[wrap_add(ptr_q, k)]) begin
        req_any = 1'b1;
        win = wrap_add(ptr_q, k);
      end
    end
  end

  assign sel_valid = i_src_valid[gidx_q];
  assign sel_last = i_src_last[gidx_q];
  assign sel_data = i_src_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign cnt_inc = cnt_q + WW'(1);
  assign ipg_inc = (ipg_q == IPG_W) ? ipg_q : ipg_q + IW'(1);

  // truncated frames keep draining through the EOF cycle
  assign o_src_ready =
    (state_q == S_DATA || state_q == S_DRAIN ||
     (state_q == S_EOF && trunc_q)) ? grant_q : '0;

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gidx_d = gidx_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    ipg_d = ipg_q;
    trunc_d = trunc_q;
    data_d = W_IDLE;
    ctrl_d = C_CTL;
    done_d = 1'b0;
    trp_d = 1'b0;
    und_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_enable && req_any) begin
          data_d = W_START;
          grant_d = NUM_SRC'(1) << win;
          gidx_d = win;
          ptr_d = wrap_add(win, 1);
          cnt_d = '0;
          trunc_d = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (sel_valid) begin
          data_d = sel_data;
          ctrl_d = '0;
          cnt_d = cnt_inc;
          if (sel_last) begin
            state_d = (cnt_inc >= MIN_W) ? S_EOF : S_PAD;
          end else if (cnt_inc == MAX_W) begin
            trunc_d = 1'b1;
            state_d = S_EOF;
          end
        end else begin
          data_d = W_EOF;
          done_d = 1'b1;
          und_d = 1'b1;
          ipg_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_PAD: begin
        data_d = W_PAD;
        ctrl_d = '0;
        cnt_d = cnt_inc;
        if (cnt_inc >= MIN_W) state_d = S_EOF;
      end
      S_EOF: begin
        data_d = W_EOF;
        done_d = 1'b1;
        trp_d = trunc_q;
        ipg_d = '0;
        trunc_d = 1'b0;
        if (trunc_q && !(sel_valid && sel_last)) state_d = S_DRAIN;
        else state_d = S_IPG;
      end
      S_DRAIN: begin
        ipg_d = ipg_inc;
        if (sel_valid && sel_last) begin
          if (ipg_inc >= IPG_W) begin
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_IPG;
          end
        end
      end
      S_IPG: begin
        ipg_d = ipg_inc;
        if (ipg_inc >= IPG_W) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      gidx_q <= '0;
      grant_q <= '0;
      cnt_q <= '0;
      ipg_q <= '0;
      trunc_q <= 1'b0;
      data_q <= W_IDLE;
      ctrl_q <= C_CTL;
      done_q <= 1'b0;
      trp_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gidx_q <= gidx_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      ipg_q <= ipg_d;
      trunc_q <= trunc_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      done_q <= done_d;
      trp_q <= trp_d;
      und_q <= und_d;
    end
  end

  assign o_tx_data = data_q;
  assign o_tx_ctrl = ctrl_q;
  assign o_grant = grant_q;
  assign o_frame_done = done_q;
  assign o_trunc = trp_q;
  assign o_underrun = und_q;
endmodule
